// File: rtl/wrr_timeout_sched_pkg.sv
// Shared types and default sizing for the weighted round-robin scheduler.
package wrr_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int WW_DEF   = 4;
  localparam int TW_DEF   = 8;

  // Width of a master index; a single master still needs one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W = ptr_w(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

endpackage

// File: rtl/wrr_timeout_sched_if.sv
// Request/grant bundle between the bus masters and the scheduler.
interface wrr_timeout_sched_if
  import wrr_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WW   = WW_DEF,
  parameter int TW   = TW_DEF
);

  logic [NREQ-1:0]         req_vec;
  logic [NREQ*WW-1:0]      req_wt_vec;
  logic                    req_n_valid;
  logic [NREQ-1:0]         end_access_vec;
  logic [TW-1:0]           timeout_cycles;
  logic [NREQ-1:0]         gnt_vec;
  logic                    timeout_pulse;
  logic [ptr_w(NREQ)-1:0]  timeout_id;
  logic                    interval_done;

  modport master (
    output req_vec, req_wt_vec, req_n_valid, end_access_vec, timeout_cycles,
    input  gnt_vec, timeout_pulse, timeout_id, interval_done
  );

  modport slave (
    input  req_vec, req_wt_vec, req_n_valid, end_access_vec, timeout_cycles,
    output gnt_vec, timeout_pulse, timeout_id, interval_done
  );

endinterface

// File: rtl/wrr_timeout_sched_rr_pick.sv
// Rotating-priority search: first eligible master strictly after last_ptr.
module rr_pick
  import wrr_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = PTR_W
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   last_ptr,
  output logic            found,
  output logic [PW-1:0]   winner
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest eligible master is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = PW'((int'(last_ptr) + i) % NREQ);
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/wrr_timeout_sched.sv
// Weighted round-robin bus scheduler with per-grant timeout.
// Each interval starts with credits equal to the weights; every grant
// spends one credit, and the interval closes once nobody eligible remains.
module wrr_timeout_sched
  import wrr_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WW   = WW_DEF,
  parameter int TW   = TW_DEF
) (
  input logic               clk,
  input logic               reset,
  wrr_timeout_sched_if.slave bus
);

  localparam int PW = ptr_w(NREQ);

  state_t          state_q, state_d;
  logic [WW-1:0]   credit_q [NREQ];
  logic [WW-1:0]   credit_d [NREQ];
  logic [WW-1:0]   weight_q [NREQ];
  logic [WW-1:0]   weight_d [NREQ];
  logic [PW-1:0]   last_ptr_q, last_ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            timeout_pulse_q, timeout_pulse_d;
  logic [PW-1:0]   timeout_id_q, timeout_id_d;
  logic            interval_done_q, interval_done_d;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [PW-1:0]   winner;
  logic            end_hit;
  logic            expire;

  // A master may compete only while it requests and still holds credit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req_vec[i] && (credit_q[i] != '0) && (weight_q[i] != '0);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .eligible (eligible),
    .last_ptr (last_ptr_q),
    .found    (found),
    .winner   (winner)
  );

  // While granted, last_ptr names the owner, so only its release bit matters.
  always_comb begin
    end_hit = bus.end_access_vec[last_ptr_q];
    expire  = (bus.timeout_cycles != '0) && (timer_q == bus.timeout_cycles - TW'(1));
  end

  // Next-state and registered-output decisions for the three-state controller.
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    weight_d        = weight_q;
    last_ptr_d      = last_ptr_q;
    timer_d         = timer_q;
    gnt_d           = gnt_q;
    timeout_pulse_d = 1'b0;
    timeout_id_d    = timeout_id_q;
    interval_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.req_n_valid) begin
          for (int i = 0; i < NREQ; i++) begin
            credit_d[i] = bus.req_wt_vec[i*WW +: WW];
            weight_d[i] = bus.req_wt_vec[i*WW +: WW];
          end
          state_d = ARB;
        end
      end

      ARB: begin
        if (found) begin
          gnt_d = '0;
          gnt_d[winner] = 1'b1;
          if (credit_q[winner] != '0) begin
            credit_d[winner] = credit_q[winner] - WW'(1);
          end
          last_ptr_d = winner;
          timer_d    = '0;
          state_d    = GRANT;
        end else begin
          gnt_d           = '0;
          interval_done_d = 1'b1;
          state_d         = IDLE;
        end
      end

      GRANT: begin
        if (end_hit) begin
          gnt_d   = '0;
          state_d = ARB;
        end else if (expire) begin
          gnt_d           = '0;
          timeout_pulse_d = 1'b1;
          timeout_id_d    = last_ptr_q;
          state_d         = ARB;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset parks the pointer on the last master so M0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      for (int i = 0; i < NREQ; i++) begin
        credit_q[i] <= '0;
        weight_q[i] <= '0;
      end
      last_ptr_q      <= PW'(NREQ - 1);
      timer_q         <= '0;
      gnt_q           <= '0;
      timeout_pulse_q <= 1'b0;
      timeout_id_q    <= '0;
      interval_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      weight_q        <= weight_d;
      last_ptr_q      <= last_ptr_d;
      timer_q         <= timer_d;
      gnt_q           <= gnt_d;
      timeout_pulse_q <= timeout_pulse_d;
      timeout_id_q    <= timeout_id_d;
      interval_done_q <= interval_done_d;
    end
  end

  assign bus.gnt_vec       = gnt_q;
  assign bus.timeout_pulse = timeout_pulse_q;
  assign bus.timeout_id    = timeout_id_q;
  assign bus.interval_done = interval_done_q;

endmodule

// File: tb/tb_wrr_timeout_sched.sv
// Self-checking bench for wrr_timeout_sched: a cycle vector table, directed
// interval scenarios, and randomized intervals against a grant-order model.
module tb_wrr_timeout_sched;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int T  = 8;
  localparam int MAXCYC = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  wrr_timeout_sched_if #(.NREQ(N), .WW(W), .TW(T)) bus ();

  wrr_timeout_sched #(.NREQ(N), .WW(W), .TW(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rnv;
    logic [3:0] ea;
    logic [3:0] e_gnt;
    logic       e_done;
  } vec_t;

  vec_t tbl [20];

  int total = 0;
  int bad   = 0;

  int hold [64];
  int m_ptr;

  int exp_id[$];
  int exp_dur[$];
  bit exp_to[$];
  int obs_id[$];
  int obs_dur[$];
  bit obs_to[$];
  int obs_tid[$];
  bit obs_done;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset              = v.rst;
    bus.req_n_valid    = v.rnv;
    bus.end_access_vec = v.ea;
    step();
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.req_n_valid    = 1'b0;
    bus.end_access_vec = '0;
    step();
    check_output("reset_gnt", {bus.gnt_vec, bus.timeout_pulse, bus.interval_done}, '0);
    reset = 1'b0;
    m_ptr = N - 1;
  endtask

  // Grant order from the scheduling rules: credits = weights, nearest requester after the pointer wins.
  task automatic model_interval(input logic [3:0] r, input logic [15:0] w, input int tmo);
    int cred [N];
    int pick;
    int j;
    int k;
    int h;
    exp_id.delete();
    exp_dur.delete();
    exp_to.delete();
    for (int i = 0; i < N; i++) cred[i] = int'(w[i*W +: W]);
    k = 0;
    forever begin
      pick = -1;
      for (int s = 1; s <= N; s++) begin
        j = (m_ptr + s) % N;
        if (r[j] && cred[j] > 0) begin
          pick = j;
          break;
        end
      end
      if (pick < 0) break;
      cred[pick]--;
      m_ptr = pick;
      exp_id.push_back(pick);
      h = hold[k];
      exp_dur.push_back((tmo != 0 && tmo <= h) ? tmo : h);
      exp_to.push_back(tmo != 0 && tmo < h);
      k++;
    end
  endtask

  // Starts one interval and records each grant episode until interval_done.
  task automatic run_interval(input logic [3:0] r, input logic [15:0] w, input logic [7:0] tmo, input bit noise);
    int cur;
    int dur;
    int cyc;
    bit ended;
    obs_id.delete();
    obs_dur.delete();
    obs_to.delete();
    obs_tid.delete();
    obs_done = 1'b0;
    bus.req_vec        = r;
    bus.req_wt_vec     = w;
    bus.timeout_cycles = tmo;
    bus.end_access_vec = '0;
    bus.req_n_valid    = 1'b1;
    step();
    bus.req_n_valid = 1'b0;
    cur = -1;
    dur = 0;
    cyc = 0;
    while (!obs_done && cyc < MAXCYC) begin
      bus.end_access_vec = noise ? 4'($urandom) : 4'b0;
      if (bus.gnt_vec != '0) begin
        if (cur < 0) begin
          for (int i = 0; i < N; i++) if (bus.gnt_vec[i]) cur = i;
          dur = 0;
        end
        dur++;
        bus.end_access_vec = bus.end_access_vec & ~bus.gnt_vec;
        if (obs_id.size() < 64 && dur == hold[obs_id.size()])
          bus.end_access_vec = bus.end_access_vec | bus.gnt_vec;
      end
      if (noise) bus.req_n_valid = ($urandom_range(0, 3) == 0);
      step();
      cyc++;
      check_output("onehot", 64'($countones(bus.gnt_vec) <= 1), 1);
      ended = (cur >= 0) && (bus.gnt_vec != (4'b0001 << cur));
      if (ended) begin
        obs_id.push_back(cur);
        obs_dur.push_back(dur);
        obs_to.push_back(bus.timeout_pulse);
        obs_tid.push_back(int'(bus.timeout_id));
        check_output("release_gap", bus.gnt_vec, 0);
        cur = -1;
      end else begin
        check_output("no_timeout_pulse", bus.timeout_pulse, 0);
      end
      if (bus.interval_done) begin
        obs_done = 1'b1;
        check_output("done_without_grant", bus.gnt_vec, 0);
      end
    end
    bus.req_n_valid    = 1'b0;
    bus.end_access_vec = '0;
    check_output("interval_bound", obs_done, 1);
  endtask

  task automatic compare_interval(input string tag);
    check_output({tag, "_count"}, obs_id.size(), exp_id.size());
    for (int i = 0; i < obs_id.size() && i < exp_id.size(); i++) begin
      check_output($sformatf("%s_id%0d", tag, i), obs_id[i], exp_id[i]);
      check_output($sformatf("%s_dur%0d", tag, i), obs_dur[i], exp_dur[i]);
      check_output($sformatf("%s_to%0d", tag, i), obs_to[i], exp_to[i]);
      if (exp_to[i]) check_output($sformatf("%s_tid%0d", tag, i), obs_tid[i], exp_id[i]);
    end
  endtask

  // Main test sequence.
  initial begin
    logic [3:0]  rr;
    logic [15:0] ww;
    int          tt;

    bus.req_vec        = '0;
    bus.req_wt_vec     = '0;
    bus.req_n_valid    = 1'b0;
    bus.end_access_vec = '0;
    bus.timeout_cycles = '0;

    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 4'h2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 4'h2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'h2, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'h1, 4'h2, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'h2, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0};

    bus.req_vec    = 4'b0111;
    bus.req_wt_vec = 16'h0021;
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(tbl[k]);
      check_output($sformatf("vec%0d", k),
                   {bus.gnt_vec, bus.timeout_pulse, bus.timeout_id, bus.interval_done},
                   {tbl[k].e_gnt, 1'b0, 2'b00, tbl[k].e_done});
    end
    reset = 1'b0;

    $display("[TB] directed: weights 1,2,3,0 with immediate release");
    do_reset();
    for (int i = 0; i < 64; i++) hold[i] = 1;
    run_interval(4'b1111, 16'h0321, 8'd0, 1'b0);
    exp_id  = '{0, 1, 2, 1, 2, 2};
    exp_dur = '{1, 1, 1, 1, 1, 1};
    exp_to  = '{0, 0, 0, 0, 0, 0};
    compare_interval("wrr_order");

    $display("[TB] directed: single requester timing out");
    do_reset();
    for (int i = 0; i < 64; i++) hold[i] = 1000;
    run_interval(4'b0100, 16'h0200, 8'd5, 1'b0);
    exp_id  = '{2, 2};
    exp_dur = '{5, 5};
    exp_to  = '{1, 1};
    compare_interval("timeout");

    $display("[TB] directed: release on the expiry cycle");
    do_reset();
    for (int i = 0; i < 64; i++) hold[i] = 3;
    run_interval(4'b0010, 16'h0010, 8'd3, 1'b0);
    exp_id  = '{1};
    exp_dur = '{3};
    exp_to  = '{0};
    compare_interval("release_wins");

    $display("[TB] randomized intervals");
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rr = 4'($urandom);
      ww = 16'($urandom);
      tt = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      for (int i = 0; i < 64; i++) hold[i] = int'($urandom_range(1, 8));
      model_interval(rr, ww, tt);
      run_interval(rr, ww, 8'(tt), 1'b1);
      compare_interval($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
